// File: rtl/res_ram_pkg.sv
// res_ram_pkg: shared constants and types for the result RAM controller.
//   ADDR_W / DATA_W / DEPTH : geometry of the 16384x8 result RAM
//   wr_state_e              : write-port owner (IDLE = producer, CLEAR = zero-fill)
//   RD_HOST / RD_SCAN       : read requester indices (arbiter bit positions)
package res_ram_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16384;  // must equal 2**ADDR_W

    // Last address written by the clear sequencer.
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wr_state_e;

    localparam int RD_HOST = 0;
    localparam int RD_SCAN = 1;

endpackage

// File: rtl/res_ram_ctrl_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter with combinational grant.
//   clock, reset_n : clock and synchronous active-low reset
//   req_i[1:0]     : request per requester
//   gnt_o[1:0]     : one-hot grant, same cycle as the request
// A lone requester always wins. On a conflict the pointer decides, and after
// every grant the pointer moves to the requester that was not granted.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;  // 0: requester 0 wins a conflict, 1: requester 1 wins

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else if (gnt_o[0]) begin
            ptr_q <= 1'b1;
        end else if (gnt_o[1]) begin
            ptr_q <= 1'b0;
        end
    end

endmodule

// File: rtl/res_ram_ctrl.sv
// res_ram_ctrl: owner of the result RAM's single write and single read port.
//   clear_start/clear_busy/clear_done : zero-fill sequencer control/status
//   wr_valid/wr_ready/wr_addr/wr_data : producer write stream (stalled only during CLEAR)
//   rdN_req/rdN_addr/rdN_gnt          : read requests, round-robin between host (rd0) and scan (rd1)
//   rdN_rvalid/rdN_data               : read return, one cycle after the grant
//   ram_*                             : direct connection to the RAM (q is 1-cycle registered)
// Optional build macro RES_RAM_BYPASS_EN: forwards same-cycle write data to a
// colliding read instead of the RAM's undefined read-during-write result.
module res_ram_ctrl
    import res_ram_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_rvalid,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_rvalid,
    output logic [DATA_W-1:0] rd1_data,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_rdaddress,
    input  logic [DATA_W-1:0] ram_q
);

    wr_state_e         state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clear_done_q;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0]        rvalid_q;
    logic [ADDR_W-1:0] rdaddr_q;
    logic [ADDR_W-1:0] rdaddr_d;
    logic [DATA_W-1:0] ret_data;

    // Write FSM: clear_start is only honoured in IDLE, so a pulse during CLEAR
    // cannot restart the fill. The counter wraps to 0 after CLR_LAST.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q      <= IDLE;
                        clear_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_done = clear_done_q;

    // Write-port mux: the producer is passed straight through while IDLE.
    always_comb begin
        wr_ready      = 1'b1;
        ram_wren      = wr_valid;
        ram_wraddress = wr_addr;
        ram_data      = wr_data;
        if (state_q == CLEAR) begin
            wr_ready      = 1'b0;
            ram_wren      = 1'b1;
            ram_wraddress = clr_cnt_q;
            ram_data      = '0;
        end
    end

    // Read arbitration; reads proceed regardless of the write FSM state.
    assign req[RD_HOST] = rd0_req;
    assign req[RD_SCAN] = rd1_req;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_i   (req),
        .gnt_o   (gnt)
    );

    assign rd0_gnt = gnt[RD_HOST];
    assign rd1_gnt = gnt[RD_SCAN];

    // The RAM read address holds its last value when nobody is granted.
    always_comb begin
        rdaddr_d = rdaddr_q;
        if (gnt[RD_HOST]) begin
            rdaddr_d = rd0_addr;
        end else if (gnt[RD_SCAN]) begin
            rdaddr_d = rd1_addr;
        end
    end

    assign ram_rdaddress = rdaddr_d;

    // The registered grant tracks the RAM's 1-cycle read latency.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rvalid_q <= 2'b00;
            rdaddr_q <= '0;
        end else begin
            rvalid_q <= gnt;
            rdaddr_q <= rdaddr_d;
        end
    end

    assign rd0_rvalid = rvalid_q[RD_HOST];
    assign rd1_rvalid = rvalid_q[RD_SCAN];

`ifdef RES_RAM_BYPASS_EN
    logic              byp_hit_q;
    logic [DATA_W-1:0] byp_data_q;

    // Capture the write data when a granted read collides with the write
    // address (clear writes included), and return it in place of ram_q.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= ram_wren && (ram_wraddress == ram_rdaddress) && (gnt != 2'b00);
            byp_data_q <= ram_data;
        end
    end

    assign ret_data = byp_hit_q ? byp_data_q : ram_q;
`else
    assign ret_data = ram_q;
`endif

    assign rd0_data = ret_data;
    assign rd1_data = ret_data;

endmodule

// File: tb/tb_res_ram_ctrl.sv
// tb_res_ram_ctrl: self-checking bench for res_ram_ctrl with a behavioural
// 16384x8 RAM (1-cycle registered read) attached to the ram_* port.
// Expected values come from a reference array of RAM contents, a one-variable
// round-robin model and the cycle-count rules of the clear sequencer.
// Define RES_RAM_BYPASS_EN for both RTL and bench to check collision forwarding.
module tb_res_ram_ctrl;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int NW = 16384;

    logic          clock;
    logic          reset_n;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd0_req;
    logic [AW-1:0] rd0_addr;
    logic          rd0_gnt;
    logic          rd0_rvalid;
    logic [DW-1:0] rd0_data;
    logic          rd1_req;
    logic [AW-1:0] rd1_addr;
    logic          rd1_gnt;
    logic          rd1_rvalid;
    logic [DW-1:0] rd1_data;
    logic          ram_wren;
    logic [AW-1:0] ram_wraddress;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_rdaddress;
    logic [DW-1:0] ram_q;

    res_ram_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd0_req       (rd0_req),
        .rd0_addr      (rd0_addr),
        .rd0_gnt       (rd0_gnt),
        .rd0_rvalid    (rd0_rvalid),
        .rd0_data      (rd0_data),
        .rd1_req       (rd1_req),
        .rd1_addr      (rd1_addr),
        .rd1_gnt       (rd1_gnt),
        .rd1_rvalid    (rd1_rvalid),
        .rd1_data      (rd1_data),
        .ram_wren      (ram_wren),
        .ram_wraddress (ram_wraddress),
        .ram_data      (ram_data),
        .ram_rdaddress (ram_rdaddress),
        .ram_q         (ram_q)
    );

    // Behavioural RAM: write and registered read on the same edge.
    logic [DW-1:0] ram_mem [NW];
    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_wraddress] <= ram_data;
        ram_q <= ram_mem[ram_rdaddress];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state.
    logic [DW-1:0] ref_mem [NW];
    bit            known   [NW];
    logic [AW-1:0] wr_q    [$];
    int            rr;          // requester favoured on the next conflict
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_ref();
        for (int i = 0; i < NW; i++) known[i] = 1'b0;
        wr_q.delete();
        rr = 0;
    endtask

    function automatic logic [AW-1:0] pick_known();
        return wr_q[$urandom_range(wr_q.size() - 1)];
    endfunction

    task automatic write_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        check("wr_ready", wr_ready, 1);
        check("wr_pass", {ram_wren, ram_wraddress, ram_data}, {1'b1, a, d});
        tick();
        wr_valid = 1'b0;
        ref_mem[a] = d; known[a] = 1'b1; wr_q.push_back(a);
    endtask

    task automatic read_one(input int port, input logic [AW-1:0] a);
        logic [DW-1:0] exp_d;
        exp_d = ref_mem[a];
        if (port == 0) begin rd0_req = 1'b1; rd0_addr = a; end
        else           begin rd1_req = 1'b1; rd1_addr = a; end
        #1;
        check("rd_gnt", {rd1_gnt, rd0_gnt}, (port == 0) ? 2'b01 : 2'b10);
        check("rd_addr", ram_rdaddress, a);
        rr = 1 - port;
        tick();
        rd0_req = 1'b0; rd1_req = 1'b0;
        check("rd_rvalid", {rd1_rvalid, rd0_rvalid}, (port == 0) ? 2'b01 : 2'b10);
        check("rd_data", (port == 0) ? rd0_data : rd1_data, exp_d);
    endtask

    // Runs one clear. restart_at: counter value at which clear_start is pulsed
    // again (-1 none). abort_at: counter value at which reset_n is pulled (-1 none).
    task automatic run_clear(input int restart_at, input int abort_at);
        int busy = 0;
        int done = 0;
        int bad  = 0;
        logic [AW-1:0] pa;
        pa = AW'($urandom);
        clear_start = 1'b1;
        wr_valid = 1'b1; wr_addr = pa; wr_data = DW'($urandom);
        #1;
        check("clr_start_wr_ready", wr_ready, 1);
        check("clr_start_wr_addr", {ram_wren, ram_wraddress}, {1'b1, pa});
        tick();
        clear_start = 1'b0; wr_valid = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (clear_done) done++;
            if (!clear_busy) break;
            if (ram_wren !== 1'b1 || ram_wraddress !== AW'(busy) || ram_data !== '0 || wr_ready !== 1'b0)
                bad++;
            if (busy == abort_at) begin
                reset_n = 1'b0;
                tick();
                check("abort_busy", clear_busy, 0);
                check("abort_done", clear_done, 0);
                check("abort_wr_ready", wr_ready, 1);
                reset_n = 1'b1;
                reset_ref();
                for (int k = 0; k < 4; k++) begin
                    tick();
                    if (clear_done || clear_busy) bad++;
                end
                check("abort_quiet", bad, 0);
                return;
            end
            clear_start = (busy == restart_at);
            busy++;
            tick();
        end
        clear_start = 1'b0;
        check("clr_busy_cycles", busy, NW);
        check("clr_done_now", clear_done, 1);
        check("clr_done_count", done, 1);
        check("clr_port_bad", bad, 0);
        tick();
        check("clr_done_one_cycle", clear_done, 0);
        check("clr_idle_ready", wr_ready, 1);
        for (int i = 0; i < NW; i++) begin ref_mem[i] = '0; known[i] = 1'b1; end
    endtask

    initial begin
        int            g;
        int            prev_g;
        logic [AW-1:0] a0, a1, ra, wa;
        logic [DW-1:0] prev_d, exp_d;

        reset_n = 1'b0; clear_start = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_req = 1'b0; rd0_addr = '0; rd1_req = 1'b0; rd1_addr = '0;
        reset_ref();
        repeat (3) tick();
        check("rst_busy", clear_busy, 0);
        check("rst_done", clear_done, 0);
        check("rst_rvalid", {rd1_rvalid, rd0_rvalid}, 2'b00);
        check("rst_wr_ready", wr_ready, 1);
        reset_n = 1'b1;
        tick();

        // 1: directed write/read, then random traffic.
        write_one(14'h0010, 8'h5A);
        read_one(0, 14'h0010);
        for (int i = 0; i < 6; i++) write_one(AW'($urandom), DW'($urandom));
        for (int i = 0; i < 6; i++) read_one(int'($urandom_range(1)), pick_known());

        // 2: full clear, then corner reads.
        run_clear(-1, -1);
        read_one(0, 14'h0000);
        read_one(1, 14'h2000);
        read_one(0, 14'h3FFF);

        // 3: both requesters held for 6 cycles.
        for (int i = 0; i < 4; i++) write_one(AW'($urandom), DW'($urandom));
        prev_g = -1; prev_d = '0; a0 = '0; a1 = '0;
        for (int c = 0; c < 6; c++) begin
            a0 = pick_known(); a1 = pick_known();
            rd0_req = 1'b1; rd0_addr = a0; rd1_req = 1'b1; rd1_addr = a1;
            #1;
            g = rr;
            check("rr_gnt", {rd1_gnt, rd0_gnt}, (g == 0) ? 2'b01 : 2'b10);
            check("rr_addr", ram_rdaddress, (g == 0) ? a0 : a1);
            if (prev_g >= 0) begin
                check("rr_rvalid", {rd1_rvalid, rd0_rvalid}, (prev_g == 0) ? 2'b01 : 2'b10);
                check("rr_data", (prev_g == 0) ? rd0_data : rd1_data, prev_d);
            end
            prev_g = g; prev_d = ref_mem[(g == 0) ? a0 : a1]; rr = 1 - g;
            tick();
        end
        rd0_req = 1'b0; rd1_req = 1'b0;
        #1;
        check("rr_last_rvalid", {rd1_rvalid, rd0_rvalid}, (prev_g == 0) ? 2'b01 : 2'b10);
        check("rr_last_data", (prev_g == 0) ? rd0_data : rd1_data, prev_d);
        check("rr_idle_gnt", {rd1_gnt, rd0_gnt}, 2'b00);
        check("rr_hold_addr", ram_rdaddress, (prev_g == 0) ? a0 : a1);
        tick();

        // 4: clear_start during CLEAR ignored; then reset aborts a clear.
        run_clear(16'h0100, -1);
        run_clear(-1, 16'h0800);

        // 5: same-cycle write and rd1 read of one address.
        wr_valid = 1'b1; wr_addr = 14'h0042; wr_data = 8'hC3;
        rd1_req = 1'b1; rd1_addr = 14'h0042;
        #1;
        check("byp_gnt", rd1_gnt, 1);
        check("byp_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0; rd1_req = 1'b0; rr = 0;
        check("byp_rvalid", rd1_rvalid, 1);
`ifdef RES_RAM_BYPASS_EN
        check("byp_data", rd1_data, 8'hC3);
`endif
        ref_mem[14'h0042] = 8'hC3; known[14'h0042] = 1'b1; wr_q.push_back(14'h0042);

        // 6: rd1 reads while the producer streams 8 writes.
        for (int i = 0; i < 4; i++) write_one(AW'($urandom), DW'($urandom));
        for (int c = 0; c < 8; c++) begin
            ra = pick_known();
            wa = AW'($urandom);
            if (wa == ra) wa = wa ^ 14'h0001;
            exp_d = ref_mem[ra];
            wr_valid = 1'b1; wr_addr = wa; wr_data = DW'($urandom);
            rd1_req = 1'b1; rd1_addr = ra;
            #1;
            check("strm_wr_ready", wr_ready, 1);
            check("strm_gnt", rd1_gnt, 1);
            ref_mem[wa] = wr_data; known[wa] = 1'b1; wr_q.push_back(wa);
            rr = 0;
            tick();
            check("strm_rvalid", rd1_rvalid, 1);
            check("strm_data", rd1_data, exp_d);
        end
        wr_valid = 1'b0; rd1_req = 1'b0;
        tick();
        read_one(0, wr_q[wr_q.size() - 1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
